// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: size codes, FSM states,
// the pipeline stage record and lane-mask / byte-parity helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // One response pipeline stage; word is the raw array word read at accept.
    typedef struct packed {
        logic        vld;
        logic        load;
        logic        err;
        logic [1:0]  size;
        logic [1:0]  k;
        logic        uns;
        logic [31:0] word;
    } pipe_t;

    // Byte lanes touched by an access of the given size at lane offset k.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] k);
        logic [3:0] m;
        case (size)
            SZ_WORD: m = 4'b1111;
            SZ_HALF: m = 4'b0011 << k;
            SZ_BYTE: m = 4'b0001 << k;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Even parity bit for each byte lane of a word.
    function automatic logic [3:0] byte_par(input logic [31:0] w);
        logic [3:0] p;
        p = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            p[b] = ^w[8*b +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load result formatting: picks the addressed byte/half lane out of a
// 32-bit array word and applies sign or zero extension.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  k_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    // Lane extract followed by extension according to access size.
    always_comb begin
        b      = word_i[7:0];
        h      = word_i[15:0];
        data_o = word_i;
        case (k_i)
            2'd0:    b = word_i[7:0];
            2'd1:    b = word_i[15:8];
            2'd2:    b = word_i[23:16];
            default: b = word_i[31:24];
        endcase
        if (k_i[1]) begin
            h = word_i[31:16];
        end
        case (size_i)
            SZ_BYTE: data_o = {{24{~uns_i & b[7]}}, b};
            SZ_HALF: data_o = {{16{~uns_i & h[15]}}, h};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores over a DEPTH-word
// array, valid/ready request port, fixed RD_LAT response pipeline, alignment
// and range checks, post-reset hardware clear of the array.
// Optional feature: define DMEM_PARITY_EN for per-byte even parity storage
// and load-side parity checking.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int AW     = 12,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [1:0]    REQ_SIZE,
    input  logic          REQ_UNSIGNED,
    input  logic [31:0]   REQ_WDATA,
    output logic          RSP_VALID,
    output logic [31:0]   RSP_RDATA,
    output logic          RSP_ERR
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [31:0]     mem_q [DEPTH];
    pipe_t           pipe_q [RD_LAT];
    pipe_t           last;

    logic            accept;
    logic [1:0]      k;
    logic [IW-1:0]   widx;
    logic            align_err;
    logic            range_err;
    logic            req_err;
    logic            par_err;
    logic [3:0]      be;
    logic [31:0]     wlanes;
    logic [31:0]     rd_word;
    logic [31:0]     aligned;

`ifdef DMEM_PARITY_EN
    logic [3:0]      par_q [DEPTH];
    logic [3:0]      rd_par;
    logic [3:0]      wpar;
`endif

    // INIT/RUN state and clear-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: sweep the clear counter once, then accept requests every cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        REQ_READY = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                REQ_READY = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Request decode: error checks, lane mask, store lane replication, array read.
    always_comb begin
        k         = REQ_ADDR[1:0];
        widx      = REQ_ADDR[IW+1:2];
        accept    = REQ_VALID & REQ_READY & ~RST;
        align_err = ((REQ_SIZE == SZ_HALF) && REQ_ADDR[0]) ||
                    ((REQ_SIZE == SZ_WORD) && (k != 2'd0));
        range_err = {2'b00, REQ_ADDR[AW-1:2]} >= AW'(DEPTH);
        req_err   = (REQ_SIZE == SZ_ILL) | align_err | range_err;
        be        = req_err ? 4'b0000 : byte_en(REQ_SIZE, k);
        case (REQ_SIZE)
            SZ_WORD: wlanes = REQ_WDATA;
            SZ_HALF: wlanes = {2{REQ_WDATA[15:0]}};
            default: wlanes = {4{REQ_WDATA[7:0]}};
        endcase
        rd_word   = range_err ? '0 : mem_q[widx];
`ifdef DMEM_PARITY_EN
        rd_par    = range_err ? '0 : par_q[widx];
        wpar      = byte_par(wlanes);
        par_err   = ~REQ_WE & (|(be & (rd_par ^ byte_par(rd_word))));
`else
        par_err   = 1'b0;
`endif
    end

    // Word array: cleared one word per cycle in INIT, lane-masked writes on accepted stores.
    always_ff @(posedge CLK) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
`ifdef DMEM_PARITY_EN
            par_q[cnt_q] <= '0;
`endif
        end else if (accept && REQ_WE) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wlanes[8*b +: 8];
`ifdef DMEM_PARITY_EN
                    par_q[widx][b] <= wpar[b];
`endif
                end
            end
        end
    end

    // Response shift register; reset drops every in-flight response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{vld:  accept,
                           load: ~REQ_WE,
                           err:  req_err | par_err,
                           size: REQ_SIZE,
                           k:    k,
                           uns:  REQ_UNSIGNED,
                           word: rd_word};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last = pipe_q[RD_LAT-1];

    dmem_load_align u_align (
        .word_i (last.word),
        .k_i    (last.k),
        .size_i (last.size),
        .uns_i  (last.uns),
        .data_o (aligned)
    );

    // Response outputs; data only for successful loads.
    always_comb begin
        RSP_VALID = last.vld;
        RSP_ERR   = last.vld & last.err;
        RSP_RDATA = (last.vld && last.load && !last.err) ? aligned : '0;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int DEPTH  = 512;
    localparam int AW     = 12;
    localparam int RD_LAT = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [1:0]    REQ_SIZE = '0;
    logic          REQ_UNSIGNED = 1'b0;
    logic [31:0]   REQ_WDATA = '0;
    logic          RSP_VALID;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_WE       (REQ_WE),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_SIZE     (REQ_SIZE),
        .REQ_UNSIGNED (REQ_UNSIGNED),
        .REQ_WDATA    (REQ_WDATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_ERR      (RSP_ERR)
    );

    typedef struct {
        bit          vld;
        bit          we;
        bit [AW-1:0] addr;
        bit [1:0]    size;
        bit          uns;
        bit [31:0]   wdata;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory as a flat little-endian byte array.
    bit [7:0]  mb [DEPTH*4];
    req_t      reqs[$];
    rsp_t      rsps[$];
    int        exp_cyc[$];
    bit [31:0] exp_rd[$];
    bit        exp_err[$];

    function automatic void model_clear();
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    endfunction

    function automatic void model(input req_t r, output bit [31:0] rd, output bit err);
        int n;
        int base;
        longint unsigned v;
        n    = (r.size == 2'd0) ? 4 : (r.size == 2'd1) ? 2 : 1;
        base = int'(r.addr);
        err  = (r.size == 2'd3) || ((base % n) != 0) || ((base / 4) >= DEPTH);
        rd   = 32'h0;
        if (err) return;
        if (r.we) begin
            for (int i = 0; i < n; i++) mb[base+i] = r.wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mb[base+i]) << (8*i));
            if (!r.uns && (((v >> (8*n-1)) & 1) == 1)) v = v | ~((64'd1 << (8*n)) - 1);
            rd = v[31:0];
        end
    endfunction

    function automatic void add(input bit vld, input bit we, input int addr, input int size,
                                input bit uns, input bit [31:0] wd);
        req_t r;
        r.vld = vld; r.we = we; r.addr = AW'(addr); r.size = 2'(size);
        r.uns = uns; r.wdata = wd;
        reqs.push_back(r);
    endfunction

    // Drives reqs one per cycle (bubbles where vld=0), records every response
    // with the cycle it was seen, and builds the model's expected stream.
    task automatic run_seq();
        bit [31:0] rd;
        bit        er;
        rsp_t      t;
        rsps.delete(); exp_cyc.delete(); exp_rd.delete(); exp_err.delete();
        for (int c = 0; c < reqs.size() + RD_LAT + 1; c++) begin
            if (c < reqs.size() && reqs[c].vld) begin
                REQ_VALID = 1'b1; REQ_WE = reqs[c].we; REQ_ADDR = reqs[c].addr;
                REQ_SIZE = reqs[c].size; REQ_UNSIGNED = reqs[c].uns; REQ_WDATA = reqs[c].wdata;
                model(reqs[c], rd, er);
                exp_rd.push_back(rd); exp_err.push_back(er); exp_cyc.push_back(c + RD_LAT - 1);
            end else begin
                REQ_VALID = 1'b0; REQ_WE = 1'($urandom); REQ_ADDR = AW'($urandom);
                REQ_SIZE = 2'($urandom); REQ_WDATA = $urandom;
            end
            @(posedge CLK); #1;
            if (RSP_VALID === 1'b1) begin
                t.cyc = c; t.rdata = RSP_RDATA; t.err = RSP_ERR;
                rsps.push_back(t);
            end
        end
        REQ_VALID = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        RST = 1'b1; REQ_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (REQ_READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", REQ_READY); end
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", RSP_VALID); end
        n_cmp++; if (RSP_RDATA !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", RSP_RDATA); end
        n_cmp++; if (RSP_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", RSP_ERR); end
        RST = 1'b0;
        cnt = 0;
        while (REQ_READY !== 1'b1 && cnt < 2*DEPTH) begin
            cnt++;
            @(posedge CLK); #1;
        end
        n_cmp++; if (cnt != DEPTH) begin n_bad++; $display("FAIL init_cycles got=%0d exp=%0d", cnt, DEPTH); end
        model_clear();
    endtask

    task automatic test_init_zero();
        reqs.delete();
        for (int i = 0; i < 6; i++) add(1, 0, 4 * $urandom_range(0, DEPTH-1), 0, 0, 0);
        add(1, 0, $urandom_range(0, DEPTH*4-1), 2, 0, 0);
        add(1, 0, 2 * $urandom_range(0, DEPTH*2-1), 1, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 8) begin n_bad++; $display("FAIL init_zero_count got=%0d exp=8", rsps.size()); end
        foreach (rsps[i]) begin
            n_cmp++; if (rsps[i].rdata !== 32'h0 || rsps[i].err !== 1'b0) begin
                n_bad++; $display("FAIL init_zero[%0d] got=%h/%b exp=0/0", i, rsps[i].rdata, rsps[i].err);
            end
        end
    endtask

    task automatic test_sign_ext();
        reqs.delete();
        add(1, 1, 'h004, 0, 0, 32'hDEADBEEF);
        add(1, 0, 'h007, 2, 1, 0);
        add(1, 0, 'h007, 2, 0, 0);
        add(1, 0, 'h004, 1, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 4) begin n_bad++; $display("FAIL sext_count got=%0d exp=4", rsps.size()); end
        else begin
            n_cmp++; if (rsps[0].rdata !== 32'h0 || rsps[0].err !== 1'b0) begin n_bad++; $display("FAIL sext_store got=%h/%b exp=0/0", rsps[0].rdata, rsps[0].err); end
            n_cmp++; if (rsps[1].rdata !== 32'h000000DE) begin n_bad++; $display("FAIL lbu got=%h exp=000000de", rsps[1].rdata); end
            n_cmp++; if (rsps[2].rdata !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL lb got=%h exp=ffffffde", rsps[2].rdata); end
            n_cmp++; if (rsps[3].rdata !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL lh got=%h exp=ffffbeef", rsps[3].rdata); end
        end
    endtask

    task automatic test_byte_merge();
        reqs.delete();
        add(1, 1, 'h008, 0, 0, 32'h11223344);
        add(1, 1, 'h009, 2, 0, 32'hAABBCC55);
        add(1, 0, 'h008, 0, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 3) begin n_bad++; $display("FAIL merge_count got=%0d exp=3", rsps.size()); end
        else begin
            n_cmp++; if (rsps[2].rdata !== 32'h11225544) begin n_bad++; $display("FAIL byte_merge got=%h exp=11225544", rsps[2].rdata); end
        end
    endtask

    task automatic test_errors();
        reqs.delete();
        add(1, 0, 'h003, 1, 0, 0);
        add(1, 1, 'h006, 0, 0, 32'h12345678);
        add(1, 0, 'h004, 0, 0, 0);
        add(1, 0, DEPTH*4, 0, 0, 0);
        add(1, 1, DEPTH*4 + 8, 2, 0, 32'h99);
        add(1, 0, 'h020, 3, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 6) begin n_bad++; $display("FAIL err_count got=%0d exp=6", rsps.size()); end
        else begin
            n_cmp++; if (rsps[0].err !== 1'b1 || rsps[0].rdata !== 32'h0) begin n_bad++; $display("FAIL err_half_mis got=%h/%b exp=0/1", rsps[0].rdata, rsps[0].err); end
            n_cmp++; if (rsps[1].err !== 1'b1) begin n_bad++; $display("FAIL err_word_mis got=%b exp=1", rsps[1].err); end
            n_cmp++; if (rsps[2].rdata !== 32'hDEADBEEF || rsps[2].err !== 1'b0) begin n_bad++; $display("FAIL err_unchanged got=%h/%b exp=deadbeef/0", rsps[2].rdata, rsps[2].err); end
            n_cmp++; if (rsps[3].err !== 1'b1 || rsps[3].rdata !== 32'h0) begin n_bad++; $display("FAIL err_range got=%h/%b exp=0/1", rsps[3].rdata, rsps[3].err); end
            n_cmp++; if (rsps[4].err !== 1'b1) begin n_bad++; $display("FAIL err_range_st got=%b exp=1", rsps[4].err); end
            n_cmp++; if (rsps[5].err !== 1'b1) begin n_bad++; $display("FAIL err_size3 got=%b exp=1", rsps[5].err); end
        end
    endtask

    task automatic test_back_to_back();
        bit [31:0] w1, w2;
        w1 = $urandom; w2 = $urandom;
        reqs.delete();
        add(1, 1, 'h040, 0, 0, w1);
        add(1, 0, 'h040, 0, 0, 0);
        add(1, 0, 'h040, 0, 0, 0);
        add(1, 1, 'h040, 0, 0, w2);
        add(1, 0, 'h040, 0, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 5) begin n_bad++; $display("FAIL b2b_count got=%0d exp=5", rsps.size()); end
        else begin
            n_cmp++; if (rsps[1].rdata !== w1) begin n_bad++; $display("FAIL st_then_ld got=%h exp=%h", rsps[1].rdata, w1); end
            n_cmp++; if (rsps[2].rdata !== w1) begin n_bad++; $display("FAIL ld_then_st got=%h exp=%h", rsps[2].rdata, w1); end
            n_cmp++; if (rsps[4].rdata !== w2) begin n_bad++; $display("FAIL ld_after_st got=%h exp=%h", rsps[4].rdata, w2); end
        end
    endtask

    task automatic test_pipeline();
        bit [31:0] want [4];
        want[0] = 32'hDEADBEEF; want[1] = 32'h11225544; want[2] = 32'h0; want[3] = 32'h0;
        reqs.delete();
        add(1, 0, 'h004, 0, 0, 0);
        add(1, 0, 'h008, 0, 0, 0);
        add(1, 0, 'h00C, 0, 0, 0);
        add(1, 0, 'h010, 0, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 4) begin n_bad++; $display("FAIL pipe_count got=%0d exp=4", rsps.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (rsps[i].cyc != RD_LAT - 1 + i) begin n_bad++; $display("FAIL pipe_cyc[%0d] got=%0d exp=%0d", i, rsps[i].cyc, RD_LAT - 1 + i); end
                n_cmp++; if (rsps[i].rdata !== want[i]) begin n_bad++; $display("FAIL pipe_order[%0d] got=%h exp=%h", i, rsps[i].rdata, want[i]); end
            end
        end
    endtask

    task automatic test_random();
        int addr, sz, n;
        reqs.delete();
        repeat (300) begin
            sz   = $urandom_range(0, 9);
            sz   = (sz < 3) ? 0 : (sz < 6) ? 1 : (sz < 9) ? 2 : 3;
            n    = (sz == 0) ? 4 : (sz == 1) ? 2 : 1;
            addr = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 63) : $urandom_range(0, (1 << AW) - 1);
            if ($urandom_range(0, 1) == 1) addr = addr - (addr % n);
            add($urandom_range(0, 9) < 8, 1'($urandom), addr, sz, 1'($urandom), $urandom);
        end
        run_seq();
        n_cmp++; if (rsps.size() != exp_rd.size()) begin n_bad++; $display("FAIL rand_count got=%0d exp=%0d", rsps.size(), exp_rd.size()); end
        for (int i = 0; i < rsps.size() && i < exp_rd.size(); i++) begin
            n_cmp++; if (rsps[i].cyc != exp_cyc[i]) begin n_bad++; $display("FAIL rand_cyc[%0d] got=%0d exp=%0d", i, rsps[i].cyc, exp_cyc[i]); end
            n_cmp++; if (rsps[i].rdata !== exp_rd[i]) begin n_bad++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rsps[i].rdata, exp_rd[i]); end
            n_cmp++; if (rsps[i].err !== exp_err[i]) begin n_bad++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, rsps[i].err, exp_err[i]); end
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        dut.par_q[4][1] = ~dut.par_q[4][1];
        reqs.delete();
        add(1, 0, 'h011, 2, 1, 0);
        add(1, 0, 'h010, 2, 1, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 2) begin n_bad++; $display("FAIL par_count got=%0d exp=2", rsps.size()); end
        else begin
            n_cmp++; if (rsps[0].err !== 1'b1 || rsps[0].rdata !== 32'h0) begin n_bad++; $display("FAIL par_bad_lane got=%h/%b exp=0/1", rsps[0].rdata, rsps[0].err); end
            n_cmp++; if (rsps[1].err !== 1'b0 || rsps[1].rdata !== exp_rd[1]) begin n_bad++; $display("FAIL par_good_lane got=%h/%b exp=%h/0", rsps[1].rdata, rsps[1].err, exp_rd[1]); end
        end
        dut.par_q[4][1] = ~dut.par_q[4][1];
    endtask
`endif

    task automatic test_reset_flush();
        int cnt;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'd0; REQ_UNSIGNED = 1'b0;
        REQ_ADDR = AW'(12'h004);
        @(posedge CLK); #1;
        REQ_ADDR = AW'(12'h008);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            n_cmp++; if (RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL flush_rsp[%0d] got=%b exp=0", i, RSP_VALID); end
            n_cmp++; if (REQ_READY !== 1'b0) begin n_bad++; $display("FAIL flush_ready[%0d] got=%b exp=0", i, REQ_READY); end
        end
        RST = 1'b0;
        cnt = 0;
        while (REQ_READY !== 1'b1 && cnt < 2*DEPTH) begin
            cnt++;
            n_cmp++; if (RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL flush_init_rsp got=%b exp=0", RSP_VALID); end
            @(posedge CLK); #1;
        end
        n_cmp++; if (cnt != DEPTH) begin n_bad++; $display("FAIL reinit_cycles got=%0d exp=%0d", cnt, DEPTH); end
        model_clear();
        reqs.delete();
        add(1, 0, 'h004, 0, 0, 0);
        add(1, 0, 'h008, 0, 0, 0);
        add(1, 0, 'h040, 0, 0, 0);
        run_seq();
        n_cmp++; if (rsps.size() != 3) begin n_bad++; $display("FAIL reinit_count got=%0d exp=3", rsps.size()); end
        foreach (rsps[i]) begin
            n_cmp++; if (rsps[i].rdata !== 32'h0 || rsps[i].err !== 1'b0) begin
                n_bad++; $display("FAIL reinit_zero[%0d] got=%h/%b exp=0/0", i, rsps[i].rdata, rsps[i].err);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_zero();
        test_sign_ext();
        test_byte_merge();
        test_errors();
        test_back_to_back();
        test_pipeline();
        test_random();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
